// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit op through an external 1-bit slice, LSB first.
// Optional macro ALU_SEQ_OVF_EN adds a registered signed-overflow flag; otherwise ovf is tied 0.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             ovf,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_ainv,
  output logic             slice_binv,
  output logic [1:0]       slice_op,
  output logic             slice_cin,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ainv_q, ainv_d, binv_q, binv_d;
  logic [1:0]       sop_q, sop_d;
  logic             arith_q, arith_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
`ifdef ALU_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             dec_ainv, dec_binv, dec_cin, dec_arith;
  logic [1:0]       dec_sop;
  logic [WIDTH-1:0] bit_sel, result_ins;
  logic             a_bit, b_bit, run;

  assign run = (state_q == ST_RUN);

  // One-hot select of the active bit; result_ins is result with slice_out merged at that bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bit_sel[gi]    = (idx_q == CW'(gi));
      assign result_ins[gi] = bit_sel[gi] ? slice_out : result_q[gi];
    end
  endgenerate

  assign a_bit = |(a_q & bit_sel);
  assign b_bit = |(b_q & bit_sel);

  always_comb begin
    dec_ainv  = 1'b0;
    dec_binv  = 1'b0;
    dec_sop   = 2'b00;
    dec_cin   = 1'b0;
    dec_arith = 1'b0;
    case (op_code)
      3'b000: dec_sop = 2'b00;
      3'b001: dec_sop = 2'b01;
      3'b010: begin dec_sop = 2'b10; dec_arith = 1'b1; end
      3'b011: begin dec_sop = 2'b10; dec_binv = 1'b1; dec_cin = 1'b1; dec_arith = 1'b1; end
      3'b100: dec_sop = 2'b11;
      3'b101: begin dec_sop = 2'b00; dec_ainv = 1'b1; dec_binv = 1'b1; end
      3'b110: begin dec_sop = 2'b01; dec_ainv = 1'b1; dec_binv = 1'b1; end
      default: begin dec_sop = 2'b00; dec_binv = 1'b1; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    ainv_d      = ainv_q;
    binv_d      = binv_q;
    sop_d       = sop_q;
    arith_d     = arith_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          a_d         = a_in;
          b_d         = b_in;
          ainv_d      = dec_ainv;
          binv_d      = dec_binv;
          sop_d       = dec_sop;
          arith_d     = dec_arith;
          carry_d     = dec_cin;
          idx_d       = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          zero_d      = 1'b0;
`ifdef ALU_SEQ_OVF_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        result_d = result_ins;
        carry_d  = slice_cout;
        idx_d    = idx_q + CW'(1);
        if (idx_q == LAST_IDX) begin
          state_d     = ST_DONE;
          carry_out_d = arith_q & slice_cout;
          zero_d      = (result_ins == '0);
`ifdef ALU_SEQ_OVF_EN
          // carry_q here is the carry into the MSB.
          ovf_d       = arith_q & (carry_q ^ slice_cout);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      ainv_q      <= 1'b0;
      binv_q      <= 1'b0;
      sop_q       <= 2'b00;
      arith_q     <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      ainv_q      <= ainv_d;
      binv_q      <= binv_d;
      sop_q       <= sop_d;
      arith_q     <= arith_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign result     = result_q;
  assign carry_out  = carry_out_q;
  assign zero       = zero_q;
`ifdef ALU_SEQ_OVF_EN
  assign ovf        = ovf_q;
`else
  assign ovf        = 1'b0;
`endif
  assign slice_a    = run & a_bit;
  assign slice_b    = run & b_bit;
  assign slice_ainv = run & ainv_q;
  assign slice_binv = run & binv_q;
  assign slice_op   = run ? sop_q : 2'b00;
  assign slice_cin  = run & carry_q;

endmodule
